// File: rtl/q_quant_core8_pkg.sv
// Shared constants and types for the 8-bit quantizer core.
package q_quant_core8_pkg;

    // Output code range of the unsigned 8-bit quantized datapath.
    localparam int QT_OUT_MIN     = 0;
    localparam int QT_OUT_MAX     = 255;

    // Cycles from an accepted INPUT_EN to its OUTPUT_EN.
    localparam int Q_CORE_LATENCY = 4;

    // Storage width of the scale inside the config record.
    localparam int QT_SCALE_W     = 32;

    // One complete quantizer configuration, swapped atomically.
    typedef struct packed {
        logic [QT_SCALE_W-1:0] scale;
        logic [4:0]            shift;
        logic [7:0]            zp;
    } qt_cfg_t;

    // Config loader: IDLE, or holding a shadow config until the pipe drains.
    typedef enum logic {
        CFG_IDLE = 1'b0,
        CFG_PEND = 1'b1
    } cfg_state_t;

endpackage

// File: rtl/q_round_shift.sv
// Round-half-up arithmetic right shift of a signed product (quantizer S3).
// shift = 0 passes the value through untouched.
module q_round_shift #(
    parameter int W = 49
) (
    input  logic signed [W-1:0] val,
    input  logic        [4:0]   shift,
    output logic signed [W-1:0] res
);

    // One guard bit so adding the rounding bias can never wrap.
    logic signed [W:0] ext;
    logic signed [W:0] bias;
    logic signed [W:0] sum;

    // Add half an LSB of the result, then shift arithmetically (floor).
    always_comb begin
        // NOTE: every signal written here gets a value before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        ext  = {val[W-1], val};
        bias = (W+1)'(1) << (shift - 5'd1);
        sum  = ext + bias;
        res  = val;
        if (shift != 5'd0) begin
            res = W'(sum >>> shift);
        end
    end

endmodule

// File: rtl/q_quant_core8.sv
// Four-stage quantizer: q = sat_u8(round(x * scale >> shift) + zp).
// Config changes are deferred until the pipeline is empty so every sample
// is processed with a single consistent config.
module q_quant_core8
    import q_quant_core8_pkg::*;
#(
    parameter int IN_W    = 16,
    parameter int SCALE_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic                CLK,
    input  logic                RESET_X,
    input  logic                INPUT_EN,
    input  logic [IN_W-1:0]     X_IN,
    output logic                OUTPUT_EN,
    output logic [7:0]          Q_OUT,
    input  logic                CFG_WE,
    input  logic [SCALE_W-1:0]  CFG_SCALE,
    input  logic [4:0]          CFG_SHIFT,
    input  logic [7:0]          CFG_ZP,
    output logic                CFG_BUSY,
    input  logic                SAT_CLR,
    output logic [CNT_W-1:0]    SAT_CNT
);

    localparam int PROD_W = IN_W + QT_SCALE_W + 1;
    localparam int V_W    = PROD_W + 1;
    localparam logic signed [V_W-1:0] V_MAX = V_W'(QT_OUT_MAX);

    // Stage valid bits and datapath registers.
    logic                     s1_v, s2_v, s3_v;
    logic signed [IN_W-1:0]   x1;
    logic signed [PROD_W-1:0] prod2;
    logic signed [V_W-1:0]    v3;

    // Operands widened to the product width before the multiply.
    logic signed [PROD_W-1:0] x_ext;
    logic signed [PROD_W-1:0] scale_ext;
    logic signed [PROD_W-1:0] r_comb;
    logic signed [V_W-1:0]    r_ext;
    logic signed [V_W-1:0]    zp_ext;

    // Clamp results for S4.
    logic [7:0] q_nxt;
    logic       sat;

    // Config state.
    cfg_state_t state, state_nxt;
    qt_cfg_t    cfg_in, cfg_act, cfg_shadow, cfg_src;
    logic       cfg_load;
    logic       pipe_empty;

    assign cfg_in     = '{scale: QT_SCALE_W'(CFG_SCALE), shift: CFG_SHIFT, zp: CFG_ZP};
    assign pipe_empty = !INPUT_EN && !s1_v && !s2_v && !s3_v;
    assign CFG_BUSY   = (state == CFG_PEND);

    assign x_ext     = PROD_W'(x1);
    assign scale_ext = PROD_W'({1'b0, cfg_act.scale});
    assign r_ext     = V_W'(r_comb);
    assign zp_ext    = V_W'({1'b0, cfg_act.zp});

    // Valid bits advance every cycle; there is no stall path.
    always_ff @(posedge CLK or negedge RESET_X) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // stage samples the previous cycle's values regardless of order.
        if (!RESET_X) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s3_v <= 1'b0;
        end else begin
            s1_v <= INPUT_EN;
            s2_v <= s1_v;
            s3_v <= s2_v;
        end
    end

    // S1 capture, S2 multiply, S3 round/shift/add-zero-point.
    always_ff @(posedge CLK) begin
        // NOTE: pure datapath registers carry no reset; their contents are
        // ignored until the matching valid bit is set.
        if (INPUT_EN) x1    <= X_IN;
        if (s1_v)     prod2 <= x_ext * scale_ext;
        if (s2_v)     v3    <= r_ext + zp_ext;
    end

    q_round_shift #(.W(PROD_W)) u_round_shift (
        .val   (prod2),
        .shift (cfg_act.shift),
        .res   (r_comb)
    );

    // S4 clamp to the unsigned 8-bit code range.
    always_comb begin
        q_nxt = v3[7:0];
        sat   = 1'b0;
        if (v3[V_W-1]) begin
            q_nxt = 8'(QT_OUT_MIN);
            sat   = 1'b1;
        end else if (v3 > V_MAX) begin
            q_nxt = 8'(QT_OUT_MAX);
            sat   = 1'b1;
        end
    end

    // Output register; Q_OUT holds between valid samples.
    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            OUTPUT_EN <= 1'b0;
            Q_OUT     <= '0;
        end else begin
            OUTPUT_EN <= s3_v;
            if (s3_v) Q_OUT <= q_nxt;
        end
    end

    // Sticky saturation counter; clear wins over a same-cycle event.
    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            SAT_CNT <= '0;
        end else if (SAT_CLR) begin
            SAT_CNT <= '0;
        end else if (s3_v && sat && (SAT_CNT != '1)) begin
            SAT_CNT <= SAT_CNT + CNT_W'(1);
        end
    end

    // Config loader next state: load now if empty, otherwise wait in PEND.
    always_comb begin
        state_nxt = state;
        cfg_load  = 1'b0;
        cfg_src   = CFG_WE ? cfg_in : cfg_shadow;
        case (state)
            CFG_IDLE: begin
                if (CFG_WE) begin
                    if (pipe_empty) cfg_load  = 1'b1;
                    else            state_nxt = CFG_PEND;
                end
            end
            CFG_PEND: begin
                if (pipe_empty) begin
                    cfg_load  = 1'b1;
                    state_nxt = CFG_IDLE;
                end
            end
            default: state_nxt = CFG_IDLE;
        endcase
    end

    // Loader state and active config; reset discards any pending load.
    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            state   <= CFG_IDLE;
            cfg_act <= '0;
        end else begin
            state <= state_nxt;
            if (cfg_load) cfg_act <= cfg_src;
        end
    end

    // Shadow copy of the most recent write.
    always_ff @(posedge CLK) begin
        if (CFG_WE) cfg_shadow <= cfg_in;
    end

endmodule

// File: tb/tb_q_quant_core8.sv
// Directed self-checking bench for q_quant_core8 and q_round_shift.
module tb_q_quant_core8;
    import q_quant_core8_pkg::*;

    localparam int IN_W    = 16;
    localparam int SCALE_W = 32;
    localparam int CNT_W   = 4;
    localparam int RS_W    = 49;

    logic               CLK;
    logic               RESET_X;
    logic               INPUT_EN;
    logic [IN_W-1:0]    X_IN;
    logic               OUTPUT_EN;
    logic [7:0]         Q_OUT;
    logic               CFG_WE;
    logic [SCALE_W-1:0] CFG_SCALE;
    logic [4:0]         CFG_SHIFT;
    logic [7:0]         CFG_ZP;
    logic               CFG_BUSY;
    logic               SAT_CLR;
    logic [CNT_W-1:0]   SAT_CNT;

    logic signed [RS_W-1:0] rs_val;
    logic        [4:0]      rs_sh;
    logic signed [RS_W-1:0] rs_res;

    int n_checks = 0;
    int n_errors = 0;

    q_quant_core8 #(.IN_W(IN_W), .SCALE_W(SCALE_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET_X(RESET_X), .INPUT_EN(INPUT_EN), .X_IN(X_IN),
        .OUTPUT_EN(OUTPUT_EN), .Q_OUT(Q_OUT), .CFG_WE(CFG_WE),
        .CFG_SCALE(CFG_SCALE), .CFG_SHIFT(CFG_SHIFT), .CFG_ZP(CFG_ZP),
        .CFG_BUSY(CFG_BUSY), .SAT_CLR(SAT_CLR), .SAT_CNT(SAT_CNT)
    );

    q_round_shift #(.W(RS_W)) u_rs (.val(rs_val), .shift(rs_sh), .res(rs_res));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one sample for one cycle (called at a negedge).
    task automatic push(input int x);
        INPUT_EN = 1'b1;
        X_IN     = IN_W'(x);
        @(negedge CLK);
        INPUT_EN = 1'b0;
    endtask

    // Wait (bounded) for the next OUTPUT_EN and check its code.
    task automatic expect_out(input string tag, input int exp);
        for (int i = 0; i < 8 && OUTPUT_EN !== 1'b1; i++) @(negedge CLK);
        check({tag, "_en"}, OUTPUT_EN, 1);
        check(tag, Q_OUT, exp);
        @(negedge CLK);
    endtask

    // Load a config with the pipeline empty; it must apply immediately.
    task automatic set_cfg(input logic [31:0] sc, input int sh, input int zp);
        CFG_WE    = 1'b1;
        CFG_SCALE = sc;
        CFG_SHIFT = 5'(sh);
        CFG_ZP    = 8'(zp);
        @(negedge CLK);
        CFG_WE = 1'b0;
        check("cfg_busy_idle_load", CFG_BUSY, 0);
    endtask

    // Three samples in flight, then one or two config writes while pending.
    task automatic cfg_flight(input int zp_old, input int zp_a, input logic two,
                              input int zp_b, input int exp40);
        INPUT_EN = 1'b1;
        X_IN = 16'd10; @(negedge CLK);
        X_IN = 16'd20; @(negedge CLK);
        X_IN = 16'd30; @(negedge CLK);
        INPUT_EN  = 1'b0;
        CFG_WE    = 1'b1;
        CFG_SCALE = 32'h0001_0000;
        CFG_SHIFT = 5'd16;
        CFG_ZP    = 8'(zp_a);
        @(negedge CLK);
        check("flight_busy0", CFG_BUSY, 1);
        check("flight_en0", OUTPUT_EN, 1);
        check("flight_q0", Q_OUT, 10 + zp_old);
        if (two) CFG_ZP = 8'(zp_b);
        else     CFG_WE = 1'b0;
        @(negedge CLK);
        CFG_WE = 1'b0;
        check("flight_busy1", CFG_BUSY, 1);
        check("flight_q1", Q_OUT, 20 + zp_old);
        @(negedge CLK);
        check("flight_busy2", CFG_BUSY, 1);
        check("flight_q2", Q_OUT, 30 + zp_old);
        @(negedge CLK);
        check("flight_busy_done", CFG_BUSY, 0);
        push(40);
        expect_out("flight_next", exp40);
    endtask

    initial begin
        longint rs_in [7] = '{98304, -98304, 5, -5, 3, 64'sd1 << 40, -(64'sd3 << 30)};
        int     rs_shv[7] = '{16, 16, 0, 1, 1, 31, 31};
        longint rs_exp[7] = '{2, -1, 5, -2, 2, 512, -1};

        RESET_X = 1'b0; INPUT_EN = 1'b0; X_IN = '0; CFG_WE = 1'b0;
        CFG_SCALE = '0; CFG_SHIFT = '0; CFG_ZP = '0; SAT_CLR = 1'b0;
        rs_val = '0; rs_sh = '0;

        // Reset state.
        repeat (2) @(negedge CLK);
        check("rst_output_en", OUTPUT_EN, 0);
        check("rst_q_out", Q_OUT, 0);
        check("rst_sat_cnt", SAT_CNT, 0);
        check("rst_cfg_busy", CFG_BUSY, 0);
        RESET_X = 1'b1;
        @(negedge CLK);

        // Standalone round-shift vectors.
        for (int i = 0; i < 7; i++) begin
            rs_val = RS_W'(rs_in[i]);
            rs_sh  = 5'(rs_shv[i]);
            #1;
            check($sformatf("round_shift_%0d", i), rs_res, rs_exp[i]);
        end
        @(negedge CLK);

        // Identity with exact latency.
        set_cfg(32'h0001_0000, 16, 128);
        INPUT_EN = 1'b1; X_IN = 16'd100;
        @(negedge CLK);
        INPUT_EN = 1'b0;
        for (int i = 1; i < Q_CORE_LATENCY; i++) begin
            check("latency_early", OUTPUT_EN, 0);
            @(negedge CLK);
        end
        check("latency_en", OUTPUT_EN, 1);
        check("identity_q", Q_OUT, 228);
        @(negedge CLK);
        check("hold_en_low", OUTPUT_EN, 0);
        check("hold_q", Q_OUT, 228);

        // Saturation both ways.
        push(-200); expect_out("sat_low", 0);
        push(300);  expect_out("sat_high", 255);
        check("sat_cnt_2", SAT_CNT, 2);

        // Clear together with a saturating sample reaching S4.
        push(-200);
        @(negedge CLK);
        @(negedge CLK);
        SAT_CLR = 1'b1;
        @(negedge CLK);
        SAT_CLR = 1'b0;
        check("clr_en", OUTPUT_EN, 1);
        check("clr_q", Q_OUT, 0);
        check("clr_sat_cnt", SAT_CNT, 0);
        @(negedge CLK);

        // Rounding.
        set_cfg(32'h0000_8000, 16, 0);  push(3);  expect_out("round_pos", 2);
        set_cfg(32'h0000_8000, 16, 10); push(-3); expect_out("round_neg", 9);
        set_cfg(32'h0000_0001, 0, 0);   push(5);  expect_out("shift0", 5);
        check("round_no_sat", SAT_CNT, 0);

        // Back-to-back stream of 64 samples.
        set_cfg(32'h0001_0000, 16, 128);
        for (int c = 0; c < 64 + Q_CORE_LATENCY; c++) begin
            if (c >= Q_CORE_LATENCY) begin
                check("stream_en", OUTPUT_EN, 1);
                check($sformatf("stream_q_%0d", c - Q_CORE_LATENCY), Q_OUT,
                      96 + c - Q_CORE_LATENCY);
            end
            INPUT_EN = (c < 64);
            X_IN     = IN_W'(-32 + c);
            @(negedge CLK);
        end
        INPUT_EN = 1'b0;
        check("stream_end", OUTPUT_EN, 0);

        // Saturation counter sticks at its maximum.
        for (int c = 0; c < 20; c++) begin
            INPUT_EN = 1'b1; X_IN = 16'd300;
            @(negedge CLK);
        end
        INPUT_EN = 1'b0;
        repeat (6) @(negedge CLK);
        check("sat_sticky", SAT_CNT, 15);

        // Config change during traffic: single write, then last-write-wins.
        cfg_flight(128, 0, 1'b0, 0, 40);
        cfg_flight(0, 50, 1'b1, 7, 47);

        // Reset with two samples in flight and a load pending.
        INPUT_EN = 1'b1;
        X_IN = 16'd10; @(negedge CLK);
        X_IN = 16'd20; @(negedge CLK);
        INPUT_EN = 1'b0;
        CFG_WE = 1'b1; CFG_ZP = 8'd99;
        @(negedge CLK);
        CFG_WE = 1'b0;
        check("mid_busy", CFG_BUSY, 1);
        RESET_X = 1'b0;
        #1;
        check("mid_rst_en", OUTPUT_EN, 0);
        check("mid_rst_sat", SAT_CNT, 0);
        check("mid_rst_busy", CFG_BUSY, 0);
        @(negedge CLK);
        RESET_X = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("mid_no_output", OUTPUT_EN, 0);
            @(negedge CLK);
        end
        check("mid_busy_after", CFG_BUSY, 0);
        push(100);
        expect_out("zero_cfg_q", 0);
        check("zero_cfg_sat", SAT_CNT, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
